// File: rtl/axi_read_slave_burst.sv
// AXI3 read slave: queues AR requests, walks FIXED/INCR/WRAP beat addresses and streams R beats from a single-cycle memory.
// Optional define AXI_RD_RANGE_CHECK_EN turns beats past MEM_BYTES into SLVERR with no memory access.
module axi_read_slave_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 2,
  parameter int AR_DEPTH  = 4,
  parameter int MEM_BYTES = 4096
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [1:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic [1:0]        ARLOCK,
  input  logic [3:0]        ARCACHE,
  input  logic [2:0]        ARPROT,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data
);

  // state | meaning
  // IDLE  | no burst active, waiting for a queued request
  // BURST | presenting beats of the active burst on R
  typedef enum logic {IDLE, BURST} state_t;

  localparam int PTR_W = $clog2(AR_DEPTH);
  localparam int ENT_W = ID_W + ADDR_W + 4 + 2 + 2;

  logic [ENT_W-1:0]  fifo_mem [AR_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, empty, push, pop;

  logic [ID_W-1:0]   h_id;
  logic [ADDR_W-1:0] h_addr;
  logic [3:0]        h_len;
  logic [1:0]        h_size, h_burst;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, next_addr, inc, mask;
  logic [3:0]        beats_left, len;
  logic [ID_W-1:0]   id;
  logic [1:0]        size, burst;
  logic              advance, busy, wrap_ok, range_err;
  logic              unused_ok;

  assign unused_ok = ^{ARLOCK, ARCACHE, ARPROT, (MEM_BYTES != 0)};

  assign full    = (count == (PTR_W+1)'(AR_DEPTH));
  assign empty   = (count == '0);
  assign ARREADY = !full;
  assign push    = ARVALID && ARREADY;
  assign {h_id, h_addr, h_len, h_size, h_burst} = fifo_mem[rd_ptr];

  always_ff @(posedge ACLK) begin
    if (push) fifo_mem[wr_ptr] <= {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // WRAP bursts of illegal length fall back to INCR stepping
  always_comb begin
    inc     = ADDR_W'(1) << size;
    mask    = (ADDR_W'({1'b0, len} + 5'd1) << size) - ADDR_W'(1);
    wrap_ok = (burst == 2'b10) &&
              (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    if (burst == 2'b00)
      next_addr = addr;
    else if (wrap_ok)
      next_addr = (addr & ~mask) | ((addr + inc) & mask);
    else
      next_addr = addr + inc;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = BURST;
        end
      end
      BURST: begin
        if (RREADY) begin
          if (beats_left != 4'd0) advance = 1'b1;
          else if (!empty)        pop     = 1'b1;
          else                    state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      addr       <= '0;
      beats_left <= '0;
      len        <= '0;
      id         <= '0;
      size       <= '0;
      burst      <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        addr       <= h_addr;
        beats_left <= h_len;
        len        <= h_len;
        id         <= h_id;
        size       <= h_size;
        burst      <= h_burst;
      end else if (advance) begin
        addr       <= next_addr;
        beats_left <= beats_left - 4'd1;
      end
    end
  end

  assign busy = (state == BURST);

`ifdef AXI_RD_RANGE_CHECK_EN
  logic [ADDR_W:0] end_addr;
  assign end_addr  = {1'b0, addr} + {1'b0, inc};
  assign range_err = busy && (end_addr > (ADDR_W+1)'(MEM_BYTES));
`else
  assign range_err = 1'b0;
`endif

  always_comb begin
    RVALID   = busy;
    RID      = busy ? id : '0;
    mem_addr = busy ? addr : '0;
    RLAST    = busy && (beats_left == 4'd0);
    mem_read = busy && !range_err;
    RDATA    = (busy && !range_err) ? mem_data : '0;
    RRESP    = range_err ? 2'b10 : 2'b00;
  end

endmodule

// File: tb/tb_axi_read_slave_burst.sv
// Directed bench for axi_read_slave_burst: latency, burst address sequences, backpressure, queueing, reset abort.
// Define AXI_RD_RANGE_CHECK_EN on both files to exercise the SLVERR path.
module tb_axi_read_slave_burst;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [1:0]  ARSIZE, ARBURST, ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID, ARREADY;
  logic [1:0]  RID, RRESP;
  logic [31:0] RDATA;
  logic        RLAST, RVALID, RREADY;
  logic [31:0] mem_addr, mem_data;
  logic        mem_read;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc = 0;

  logic [31:0] b_addr[$];
  logic [31:0] b_data[$];
  logic [1:0]  b_id[$];
  logic [1:0]  b_resp[$];
  logic        b_last[$];
  logic        b_mread[$];
  int          b_cyc[$];

  axi_read_slave_burst dut (
    .ACLK(ACLK), .ARESET(ARESET), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
    .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .mem_addr(mem_addr), .mem_read(mem_read), .mem_data(mem_data)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign mem_data = exp_data(mem_addr);

  task automatic clear_beats();
    b_addr.delete(); b_data.delete(); b_id.delete();
    b_resp.delete(); b_last.delete(); b_mread.delete(); b_cyc.delete();
  endtask

  // entered and left just after a rising edge
  task automatic send_ar(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] size, input logic [1:0] burst);
    bit done = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge ACLK);
      done = ARREADY;
      @(posedge ACLK); #1;
    end
    ARVALID = 1'b0;
    hs_cyc = cyc;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL ar_timeout: ARREADY never seen, required 1");
    end
  endtask

  task automatic collect(input int n, input int budget);
    int got = 0;
    RREADY = 1'b1;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge ACLK);
      if (RVALID) begin
        b_addr.push_back(mem_addr); b_data.push_back(RDATA); b_id.push_back(RID);
        b_resp.push_back(RRESP); b_last.push_back(RLAST); b_mread.push_back(mem_read);
        b_cyc.push_back(cyc);
        got++;
      end
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    if (got < n) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1; ARVALID = 0; RREADY = 0; ARID = 0; ARADDR = 0; ARLEN = 0;
    ARSIZE = 0; ARBURST = 0; ARLOCK = 0; ARCACHE = 0; ARPROT = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    n_cmp++;
    if ({ARREADY, RVALID, RLAST, mem_read, RRESP, RID, mem_addr, RDATA} !== {1'b1, 71'd0}) begin
      n_bad++;
      $display("FAIL reset_outputs: ARREADY=%b RVALID=%b RLAST=%b mem_read=%b RRESP=%b RID=%h mem_addr=%h RDATA=%h, required ARREADY=1 rest 0",
               ARREADY, RVALID, RLAST, mem_read, RRESP, RID, mem_addr, RDATA);
    end
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
  endtask

  task automatic test_single();
    clear_beats();
    send_ar(2'd1, 32'h10, 4'd0, 2'd2, 2'b01);
    @(negedge ACLK);
    n_cmp++;
    if (RVALID !== 1'b0) begin
      n_bad++; $display("FAIL single_early_rvalid: RVALID=%b, required 0", RVALID);
    end
    @(posedge ACLK); #1;
    collect(1, 20);
    n_cmp++;
    if (b_addr.size() != 1 || b_cyc[0] != hs_cyc + 1) begin
      n_bad++; $display("FAIL single_latency: beats=%0d at cycle offset %0d, required 1 beat at offset 1",
                        b_addr.size(), b_cyc.size() > 0 ? b_cyc[0] - hs_cyc : -1);
    end
    n_cmp++;
    if (b_addr.size() != 1 || {b_addr[0], b_id[0], b_last[0], b_resp[0], b_data[0]} !==
        {32'h10, 2'd1, 1'b1, 2'b00, exp_data(32'h10)}) begin
      n_bad++; $display("FAIL single_beat: addr=%h id=%h last=%b resp=%b, required 00000010 1 1 00",
                        b_addr[0], b_id[0], b_last[0], b_resp[0]);
    end
  endtask

  // each entry: id, addr, len, size, burst, followed by the expected beat addresses
  task automatic test_bursts();
    logic [31:0] ea [7][4] = '{
      '{32'h100, 32'h104, 32'h108, 32'h10C},
      '{32'h38, 32'h3C, 32'h30, 32'h34},
      '{32'h38, 32'h38, 32'h38, 32'h38},
      '{32'h5, 32'h6, 32'h7, 32'h4},
      '{32'h38, 32'h3C, 32'h40, 32'h0},
      '{32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0},
      '{32'h20, 32'h22, 32'h0, 32'h0}};
    logic [3:0]  lens [7]   = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd1};
    logic [1:0]  sizes [7]  = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd1};
    logic [1:0]  bursts [7] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
    string       names [7]  = '{"incr", "wrap", "fixed", "wrap_byte", "wrap_badlen", "incr_rollover", "reserved"};
    for (int t = 0; t < 7; t++) begin
      int n = int'(lens[t]) + 1;
      clear_beats();
      send_ar(2'(t), ea[t][0], lens[t], sizes[t], bursts[t]);
      collect(n, 40);
      for (int i = 0; i < n && i < b_addr.size(); i++) begin
        n_cmp++;
        if ({b_addr[i], b_data[i], b_id[i], b_last[i], b_resp[i]} !==
            {ea[t][i], exp_data(ea[t][i]), 2'(t), (i == n - 1), 2'b00}) begin
          n_bad++;
          $display("FAIL %s_beat%0d: addr=%h id=%h last=%b resp=%b, required addr=%h id=%h last=%b resp=00",
                   names[t], i, b_addr[i], b_id[i], b_last[i], b_resp[i], ea[t][i], 2'(t), (i == n - 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
    int got = 0;
    int stall = 0;
    clear_beats();
    send_ar(2'd3, 32'h200, 4'd3, 2'd2, 2'b01);
    for (int i = 0; i < 60 && got < 4; i++) begin
      if (got == 2 && stall < 3) begin
        RREADY = 1'b0;
        @(negedge ACLK);
        n_cmp++;
        if ({RVALID, mem_addr, RLAST, RDATA} !== {1'b1, 32'h208, 1'b0, exp_data(32'h208)}) begin
          n_bad++;
          $display("FAIL bp_stall%0d: RVALID=%b addr=%h last=%b data=%h, required 1 00000208 0 %h",
                   stall, RVALID, mem_addr, RLAST, RDATA, exp_data(32'h208));
        end
        stall++;
      end else begin
        RREADY = 1'b1;
        @(negedge ACLK);
        if (RVALID) begin
          b_addr.push_back(mem_addr); b_last.push_back(RLAST);
          got++;
        end
      end
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    n_cmp++;
    if (b_addr.size() != 4) begin
      n_bad++; $display("FAIL bp_count: beats=%0d, required 4", b_addr.size());
    end
    for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
      n_cmp++;
      if ({b_addr[i], b_last[i]} !== {ea[i], (i == 3)}) begin
        n_bad++; $display("FAIL bp_beat%0d: addr=%h last=%b, required %h %b", i, b_addr[i], b_last[i], ea[i], (i == 3));
      end
    end
  endtask

  task automatic test_queue();
    RREADY = 1'b0;
    clear_beats();
    for (int r = 0; r < 5; r++) send_ar(2'(r), 32'h400 + 32'(r * 'h40), 4'd1, 2'd2, 2'b01);
    repeat (2) begin
      @(negedge ACLK);
      n_cmp++;
      if (ARREADY !== 1'b0) begin
        n_bad++; $display("FAIL queue_full: ARREADY=%b, required 0", ARREADY);
      end
      @(posedge ACLK); #1;
    end
    collect(10, 60);
    for (int i = 0; i < 10 && i < b_addr.size(); i++) begin
      logic [31:0] a = 32'h400 + 32'((i / 2) * 'h40) + 32'((i % 2) * 4);
      n_cmp++;
      if ({b_addr[i], b_id[i], b_last[i]} !== {a, 2'(i / 2), (i % 2 == 1)} || b_cyc[i] != b_cyc[0] + i) begin
        n_bad++;
        $display("FAIL queue_beat%0d: addr=%h id=%h last=%b cycle_gap=%0d, required %h %h %b 0",
                 i, b_addr[i], b_id[i], b_last[i], b_cyc[i] - b_cyc[0] - i, a, 2'(i / 2), (i % 2 == 1));
      end
    end
    @(negedge ACLK);
    n_cmp++;
    if ({ARREADY, RVALID} !== 2'b10) begin
      n_bad++; $display("FAIL queue_drained: ARREADY=%b RVALID=%b, required 1 0", ARREADY, RVALID);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_reset_mid();
    bit stray = 0;
    RREADY = 1'b0;
    clear_beats();
    send_ar(2'd1, 32'h600, 4'd7, 2'd2, 2'b01);
    send_ar(2'd2, 32'h700, 4'd0, 2'd2, 2'b01);
    collect(2, 20);
    ARESET = 1'b1;
    #1;
    n_cmp++;
    if ({RVALID, ARREADY, RLAST, mem_read} !== 4'b0100) begin
      n_bad++; $display("FAIL reset_mid: RVALID=%b ARREADY=%b RLAST=%b mem_read=%b, required 0 1 0 0",
                        RVALID, ARREADY, RLAST, mem_read);
    end
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESET = 1'b0;
    RREADY = 1'b1;
    repeat (5) begin
      @(negedge ACLK);
      if (RVALID) stray = 1;
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    n_cmp++;
    if (stray) begin
      n_bad++; $display("FAIL reset_discard: RVALID seen after reset, required none");
    end
    clear_beats();
    send_ar(2'd3, 32'h80, 4'd0, 2'd2, 2'b01);
    collect(1, 20);
    n_cmp++;
    if (b_addr.size() != 1 || {b_addr[0], b_id[0], b_last[0]} !== {32'h80, 2'd3, 1'b1}) begin
      n_bad++; $display("FAIL reset_recover: beats=%0d addr=%h id=%h last=%b, required 1 00000080 3 1",
                        b_addr.size(), b_addr[0], b_id[0], b_last[0]);
    end
  endtask

  task automatic test_range();
`ifdef AXI_RD_RANGE_CHECK_EN
    logic [1:0]  er [2] = '{2'b00, 2'b10};
    logic [31:0] ed [2] = '{exp_data(32'hFFC), 32'h0};
    logic        em [2] = '{1'b1, 1'b0};
`else
    logic [1:0]  er [2] = '{2'b00, 2'b00};
    logic [31:0] ed [2] = '{exp_data(32'hFFC), exp_data(32'h1000)};
    logic        em [2] = '{1'b1, 1'b1};
`endif
    clear_beats();
    send_ar(2'd0, 32'hFFC, 4'd1, 2'd2, 2'b01);
    collect(2, 20);
    for (int i = 0; i < 2 && i < b_addr.size(); i++) begin
      n_cmp++;
      if ({b_resp[i], b_data[i], b_mread[i], b_last[i]} !== {er[i], ed[i], em[i], (i == 1)}) begin
        n_bad++;
        $display("FAIL range_beat%0d: resp=%b data=%h mem_read=%b last=%b, required %b %h %b %b",
                 i, b_resp[i], b_data[i], b_mread[i], b_last[i], er[i], ed[i], em[i], (i == 1));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_bursts();
    test_backpressure();
    test_queue();
    test_reset_mid();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
